vga_tile_render: RTL
====================

Name: vga_tile_render

Overview:
- Pixel-generation stage directly downstream of the 640x480 VGA timing generator.
- Consumes `valid`, `h_cnt`, `v_cnt`, `hsync` and `vsync` from that generator.
- Fetches a 4-bit tile colour index from an external synchronous tile-map memory and maps it through a 16-entry palette.
- Overlays the player square and drives 12-bit RGB plus latency-matched sync signals to the DAC/pins.

Parameters:
- MEM_LAT, 2, tile-map memory read latency in cycles, from `tile_addr` registered to `tile_data` valid; legal range 1..4.
- PLAYER_SIZE, 8, side length in pixels of the player square; legal range 1..32.
- PLAYER_RGB, 12'hFFF, colour of the player square.

Ports:
- pclk  in  1  pixel clock; all logic rises on pclk.
- reset  in  1  synchronous active-low reset (0 = reset).
- valid  in  1  active-video flag from the timing generator.
- h_cnt  in  10  active-area column 0..639; 0 outside active video.
- v_cnt  in  10  active-area row 0..479; 0 outside active video.
- hsync  in  1  horizontal sync, active-low.
- vsync  in  1  vertical sync, active-low.
- tile_addr  out  11  tile-map read address, 0..1199.
- tile_data  in  4  palette index, valid MEM_LAT cycles after `tile_addr`.
- pal_we  in  1  palette write strobe.
- pal_addr  in  4  palette entry to write.
- pal_wdata  in  12  palette colour {R4,G4,B4}.
- player_x  in  10  player top-left column; live value.
- player_y  in  10  player top-left row; live value.
- rgb  out  12  pixel colour; 0 when blanked.
- hsync_o  out  1  `hsync` delayed by LAT.
- vsync_o  out  1  `vsync` delayed by LAT.
- frame_tick  out  1  one-cycle pulse at each frame start.
- frame_cnt  out  16  frame counter.

Behaviour:
- LAT = MEM_LAT + 2. `rgb`, `hsync_o` and `vsync_o` for input cycle T appear at cycle T + LAT.
- Stage A (cycle T+1):
  - `tile_addr <= (v_cnt>>4)*40 + (h_cnt>>4)`, computed as an 11-bit value.
  - The multiply by 40 is implemented as (y<<5) + (y<<3).
  - `valid`, `h_cnt`, `v_cnt`, `hsync` and `vsync` enter a delay line.
- Memory stage: `tile_data` is sampled at T+1+MEM_LAT.
- Stage C (cycle T+LAT), `rgb` is registered as:
  - 0 if delayed `valid` is 0;
  - else PLAYER_RGB if the delayed pixel is inside the player square;
  - else `palette[tile_data]`.
- Player-square test, using 11-bit sums so there is no wrap-around:
  - px_l <= hd < px_l + PLAYER_SIZE, and
  - py_l <= vd < py_l + PLAYER_SIZE.
  - Squares that extend past 639/479 are clipped.
- Frame start is the rising edge of `vsync`, detected with a registered previous value.
  - At frame start: `frame_tick` = 1 for one cycle and `frame_cnt` increments, wrapping 65535 -> 0.
  - At frame start: `player_x` and `player_y` are latched into px_l and py_l.
  - Mid-frame changes to `player_x`/`player_y` are invisible until the next frame start.
- Palette: 16x12 register file.
  - A write lands at the clock edge on which `pal_we` = 1.
  - A same-cycle read of the entry being written returns the old value.
- Reset (`reset` == 0 at a pclk edge, at any time including mid-line):
  - Outputs: `rgb` = 0, `hsync_o` = `vsync_o` = 1, `tile_addr` = 0, `frame_tick` = 0, `frame_cnt` = 0.
  - Internal state: all delay-line stages cleared with valid = 0 and syncs = 1; all palette entries = 0; px_l = py_l = 0; previous-vsync register = 1.
- After reset release, outputs follow the inputs after LAT cycles. No spurious `frame_tick` unless `vsync` genuinely rises.

Optional Feature:
- VGA_TILE_RENDER_DEBUG_GRID_EN:
  - When defined: pixels with hd[4:0] == 0 or vd[4:0] == 0 are forced to 12'h0F0.
  - The grid has priority below the player square and above the palette colour, and applies only while delayed `valid` = 1.
- When undefined: no grid logic is built, and the output is bit-identical to the colour rule in Behaviour.

Decomposition:
- Package `vga_pkg` holds:
  - H_ACTIVE = 640, V_ACTIVE = 480, TILE_SHIFT = 4, TILES_X = 40, TILE_COUNT = 1200;
  - RGB_W = 12 and a typedef rgb_t;
  - GRID_RGB = 12'h0F0.
- One sub-module `vga_delay`: parameterised width/depth shift register with a synchronous active-low clear. It is used for the valid/h/v/sync delay.

Test Plan:
- LAT check, MEM_LAT = 2: tile memory model returns index 3, palette[3] = 12'h123, player off-screen, `valid` first rises at cycle T -> `rgb` = 12'h123 first at T+4, with `hsync_o`/`vsync_o` equal to `hsync`/`vsync` delayed 4 cycles.
- Address map: h = 639, v = 479 -> `tile_addr` = 1199 one cycle later; h = 16, v = 16 -> 41; h = v = 0 -> 0.
- Blanking: `valid` = 0 while `tile_data` = 5 and palette[5] = 12'hFFF -> `rgb` = 0 throughout.
- Player overlay: `player_x` = 636, `player_y` = 0 latched at frame start -> PLAYER_RGB appears at columns 636..639 of rows 0..7 only, with no pixels at columns 0..3.
- Frame latch: `player_x` changes mid-frame -> square unchanged until the next `vsync` rise; that rise gives a one-cycle `frame_tick` and `frame_cnt` incremented; `frame_cnt` = 65535 -> 0.
- Palette collision plus reset: write palette[2] = 12'hABC in the same cycle palette[2] is read -> that pixel shows the old value and the next pixel shows 12'hABC. Then `reset` = 0 mid-line -> `rgb` = 0, syncs = 1, and palette[2] reads 0 afterwards.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, colour type and tile-address helper for the VGA tile renderer.
package vga_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int TILE_SHIFT = 4;
  localparam int TILES_X    = 40;
  localparam int TILE_COUNT = 1200;
  localparam int RGB_W      = 12;

  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t GRID_RGB = 12'h0F0;

  // Row-major tile index; the *40 is two shifts and an add so it stays in plain adders.
  function automatic logic [10:0] tile_index(input logic [9:0] h, input logic [9:0] v);
    logic [10:0] tx;
    logic [10:0] ty;
    tx = 11'(h >> TILE_SHIFT);
    ty = 11'(v >> TILE_SHIFT);
    return (ty << 5) + (ty << 3) + tx;
  endfunction

endpackage

// File: rtl/vga_delay.sv
// Fixed-depth shift register with a synchronous active-low clear to a programmable value.
module vga_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] stage_d;
    logic [WIDTH-1:0] stage_q;

    if (gi == 0) begin : g_head
      assign stage_d = din;
    end else begin : g_tail
      assign stage_d = g_stage[gi-1].stage_q;
    end

    always_ff @(posedge clk) begin
      if (!clr_n) begin
        stage_q <= CLR_VAL;
      end else begin
        stage_q <= stage_d;
      end
    end
  end

  assign dout = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/vga_tile_render.sv
// Tile-map pixel stage: address, palette lookup, player overlay and sync re-alignment.
// Optional debug grid overlay is built only when VGA_TILE_RENDER_DEBUG_GRID_EN is defined.
module vga_tile_render
  import vga_pkg::*;
#(
  parameter int          MEM_LAT     = 2,
  parameter int          PLAYER_SIZE = 8,
  parameter logic [11:0] PLAYER_RGB  = 12'hFFF
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        valid,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        hsync,
  input  logic        vsync,
  output logic [10:0] tile_addr,
  input  logic [3:0]  tile_data,
  input  logic        pal_we,
  input  logic [3:0]  pal_addr,
  input  logic [11:0] pal_wdata,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  output logic [11:0] rgb,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        frame_tick,
  output logic [15:0] frame_cnt
);

  localparam int               DLY_W     = 23;
  localparam int               DLY_DEPTH = MEM_LAT + 1;
  localparam logic [DLY_W-1:0] DLY_CLR   = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1};
  localparam logic [10:0]      SIZE_W    = 11'(PLAYER_SIZE);

  // Stage A: tile address
  logic [10:0] tile_addr_d;
  logic [10:0] tile_addr_q;

  always_comb begin
    tile_addr_d = tile_index(h_cnt, v_cnt);
  end

  always_ff @(posedge pclk) begin
    if (!reset) begin
      tile_addr_q <= '0;
    end else begin
      tile_addr_q <= tile_addr_d;
    end
  end

  assign tile_addr = tile_addr_q;

  // Pixel attributes ride alongside the memory read so they line up with tile_data.
  logic [DLY_W-1:0] dly_in;
  logic [DLY_W-1:0] dly_out;
  logic             vld_m;
  logic [9:0]       hd_m;
  logic [9:0]       vd_m;
  logic             hs_m;
  logic             vs_m;

  assign dly_in = {valid, h_cnt, v_cnt, hsync, vsync};

  vga_delay #(
    .WIDTH  (DLY_W),
    .DEPTH  (DLY_DEPTH),
    .CLR_VAL(DLY_CLR)
  ) u_delay (
    .clk  (pclk),
    .clr_n(reset),
    .din  (dly_in),
    .dout (dly_out)
  );

  assign {vld_m, hd_m, vd_m, hs_m, vs_m} = dly_out;

  // Frame start and player-position latch
  logic        vs_prev_q;
  logic        frame_start;
  logic        frame_tick_q;
  logic [15:0] frame_cnt_d;
  logic [15:0] frame_cnt_q;
  logic [9:0]  px_l_d;
  logic [9:0]  px_l_q;
  logic [9:0]  py_l_d;
  logic [9:0]  py_l_q;

  assign frame_start = vsync & ~vs_prev_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    px_l_d      = px_l_q;
    py_l_d      = py_l_q;
    if (frame_start) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      px_l_d      = player_x;
      py_l_d      = player_y;
    end
  end

  always_ff @(posedge pclk) begin
    if (!reset) begin
      vs_prev_q    <= 1'b1;
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= '0;
      px_l_q       <= '0;
      py_l_q       <= '0;
    end else begin
      vs_prev_q    <= vsync;
      frame_tick_q <= frame_start;
      frame_cnt_q  <= frame_cnt_d;
      px_l_q       <= px_l_d;
      py_l_q       <= py_l_d;
    end
  end

  assign frame_tick = frame_tick_q;
  assign frame_cnt  = frame_cnt_q;

  // Palette: a write lands on the edge, so a same-cycle read still sees the old entry.
  rgb_t pal_q [16];
  rgb_t pal_rd;

  always_ff @(posedge pclk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        pal_q[i] <= '0;
      end
    end else if (pal_we) begin
      pal_q[pal_addr] <= pal_wdata;
    end
  end

  assign pal_rd = pal_q[tile_data];

  // Player square, compared in 11 bits so the right/bottom edge never wraps.
  logic [10:0] hd_w;
  logic [10:0] vd_w;
  logic [10:0] px_w;
  logic [10:0] py_w;
  logic        in_player;

  assign hd_w = {1'b0, hd_m};
  assign vd_w = {1'b0, vd_m};
  assign px_w = {1'b0, px_l_q};
  assign py_w = {1'b0, py_l_q};

  assign in_player = (hd_w >= px_w) && (hd_w < px_w + SIZE_W) &&
                     (vd_w >= py_w) && (vd_w < py_w + SIZE_W);

  // Stage C: colour select and output registers
  rgb_t rgb_d;
  rgb_t rgb_q;
  logic hs_q;
  logic vs_q;

  always_comb begin
    rgb_d = '0;
    if (vld_m) begin
      rgb_d = pal_rd;
`ifdef VGA_TILE_RENDER_DEBUG_GRID_EN
      if (hd_m[4:0] == 5'd0 || vd_m[4:0] == 5'd0) begin
        rgb_d = GRID_RGB;
      end
`endif
      if (in_player) begin
        rgb_d = PLAYER_RGB;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!reset) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= hs_m;
      vs_q  <= vs_m;
    end
  end

  assign rgb     = rgb_q;
  assign hsync_o = hs_q;
  assign vsync_o = vs_q;

endmodule
